encoder_16_to_4_queue: RTL and testbench
========================================

# encoder_16_to_4_queue

Sequential 16-to-4 priority encoder that is the return path of the 4-to-16 decoder family. It collects request pulses on 16 one-hot or multi-hot lines into a sticky pending set, then emits one 4-bit code per request over a valid/ready handshake. Each serviced bit is cleared on acceptance. It sits between event sources and any consumer of encoded line numbers, including the decoder itself in loopback.

## Interface
Parameters:
- PRIORITY_HIGH, 1, 1 = highest index served first, 0 = lowest index first

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  active-low, same polarity as the decoder family; 1 blocks loading of new codes
- req  input  16  request lines; a 1 on bit i for one cycle marks line i pending
- out_code  output  4  encoded line number, valid while out_valid=1
- out_valid  output  1  out_code is presented
- out_ready  input  1  consumer accepts out_code when out_valid & out_ready
- pending  output  16  current sticky pending set, registered
- any  output  1  pending != 0 or out_valid=1

## Operation
- Reset: pending=0, out_code=0, out_valid=0, any=0, FSM=IDLE.
- Pending update every edge: pending_next = (pending & ~clr) | req.
  - clr is the one-hot of out_code on a handshake cycle, else 0.
  - Because req is ORed after the clear, a re-request of the line being accepted in the same cycle stays pending.
- Candidate set on each edge: cand = (pending & ~clr) | req.
- FSM IDLE: if enable=0 and cand!=0, load out_code=pe(cand & ~hold_mask) and set out_valid=1, then go to PRESENT.
  - pe() is the priority encode per PRIORITY_HIGH.
  - In IDLE, hold_mask=0. Otherwise stay in IDLE.
- FSM PRESENT: out_code and out_valid are held stable until the handshake.
  - The code in flight stays set in pending until it is accepted. It is never selected twice, because selection excludes the presented bit.
  - On a handshake with enable=0 and cand!=0: load the next code in the same edge and stay in PRESENT. Back-to-back throughput is 1 code per cycle.
  - On a handshake with enable=1 or cand=0: out_valid=0, go to IDLE.
- Raising enable (disable) while in PRESENT does not withdraw the current code. It only prevents the next load.
- Repeated req on an already-pending line merges. No count is kept and no duplicate code is emitted.
- any = |pending | out_valid, registered from next-state values.

## Timing
- Latency: req bit sampled at edge k with FSM in IDLE and enable=0 gives out_valid=1 with the code after edge k (1 cycle).
- After a handshake at edge k, the next code is presented after the same edge k (0 bubble).
- out_code must not change while out_valid=1 and out_ready=0.
- Asserting rst_n=0 mid-operation clears everything immediately, asynchronously. An unaccepted code is dropped.
- The first edge after reset release behaves as IDLE.

## Structure
- Package encoder_pkg holds:
  - constants LINES=16 and CODE_W=4
  - state enum {IDLE, PRESENT}
  - function onehot16(code)
- Sub-module priority_enc_16 (combinational): inputs vec[15:0] and dir; outputs code[3:0] and nz. Instantiated once for selection.
- The top holds the pending register, output register and FSM.

## Test plan
- Reset: hold rst_n=0 with req=16'hFFFF. Require out_valid=0, pending=0, any=0. After release with req=0, outputs stay at 0.
- Single request: enable=0, out_ready=1, pulse req=16'h0020 for 1 cycle.
  - Require out_code=5, out_valid=1 in the following cycle.
  - Then out_valid=0 and pending=0 one cycle later.
- Burst, backpressure then drain, PRIORITY_HIGH=1:
  - Pulse req=16'h8101 with out_ready=0. Require out_code=15 held for 5 cycles.
  - Then raise out_ready. Require codes 15, 8, 0 on consecutive cycles, then out_valid=0.
- Same-cycle re-request: while code 3 is presented, pulse req=16'h0008 on the handshake cycle.
  - Require code 3 to be presented again on the next cycle, and pending[3]=1 in between.
- Enable gating: enable=1, pulse req=16'h0404. Require out_valid=0 and pending=16'h0404.
  - Set enable=0. Require code 10 on the next cycle.
  - Raise enable while code 10 is in PRESENT. Require code 10 to remain held until accepted, then out_valid=0 with pending=16'h0004.
- PRIORITY_HIGH=0: req=16'h8101, out_ready=1. Require codes 0, 8, 15 on consecutive cycles.
- Async reset mid-operation: with code 8 presented and pending=16'h0101, assert rst_n=0 between edges.
  - Require out_valid=0 and pending=0 immediately, before the next edge.

Source files
------------

// File: rtl/encoder_16_to_4_queue_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 16-to-4 encoder queue.
package encoder_pkg;

  localparam int LINES  = 16;
  localparam int CODE_W = 4;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  function automatic logic [LINES-1:0] onehot16(input logic [CODE_W-1:0] code);
    return LINES'(1) << code;
  endfunction

endpackage

// File: rtl/encoder_16_to_4_queue_priority_enc.sv
// Combinational 16-line priority encoder; dir=1 picks the highest set index, dir=0 the lowest.
module priority_enc_16
  import encoder_pkg::*;
(
  input  logic [LINES-1:0]  vec,
  input  logic              dir,
  output logic [CODE_W-1:0] code,
  output logic              nz
);

  // Later matches overwrite earlier ones, so scan order decides which end wins.
  always_comb begin
    code = '0;
    nz   = |vec;
    if (dir) begin
      for (int i = 0; i < LINES; i++) begin
        if (vec[i]) code = CODE_W'(i);
      end
    end else begin
      for (int i = LINES - 1; i >= 0; i--) begin
        if (vec[i]) code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder_16_to_4_queue.sv
// Sticky pending set of request lines drained one 4-bit code per handshake, zero-bubble back to back.
module encoder_16_to_4_queue
  import encoder_pkg::*;
#(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [LINES-1:0]  req,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINES-1:0]  pending,
  output logic              any
);

  state_t             state;
  state_t             state_next;
  logic               handshake;
  logic [LINES-1:0]   clr;
  logic [LINES-1:0]   cand;
  logic [LINES-1:0]   hold_mask;
  logic [CODE_W-1:0]  sel_code;
  logic               sel_nz;
  logic               load_ok;
  logic [CODE_W-1:0]  code_next;
  logic               valid_next;

  // req is ORed after the clear so a same-cycle re-request of the accepted line survives.
  assign handshake = out_valid & out_ready;
  assign clr       = handshake ? onehot16(out_code) : '0;
  assign cand      = (pending & ~clr) | req;
  assign hold_mask = (state == PRESENT && !handshake) ? onehot16(out_code) : '0;
  assign load_ok   = !enable && sel_nz;

  priority_enc_16 u_sel (
    .vec  (cand & ~hold_mask),
    .dir  (PRIORITY_HIGH != 0),
    .code (sel_code),
    .nz   (sel_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_ok) state_next = PRESENT;
      PRESENT: if (handshake && !load_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A presented code is only replaced on its own handshake, never while stalled.
  always_comb begin
    code_next  = out_code;
    valid_next = out_valid;
    case (state)
      IDLE: begin
        if (load_ok) begin
          code_next  = sel_code;
          valid_next = 1'b1;
        end
      end
      PRESENT: begin
        if (handshake) begin
          if (load_ok) begin
            code_next  = sel_code;
            valid_next = 1'b1;
          end else begin
            valid_next = 1'b0;
          end
        end
      end
      default: valid_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_code  <= '0;
      out_valid <= 1'b0;
      any       <= 1'b0;
    end else begin
      pending   <= cand;
      out_code  <= code_next;
      out_valid <= valid_next;
      any       <= (|cand) | valid_next;
    end
  end

endmodule

// File: tb/tb_encoder_16_to_4_queue.sv
// Directed bench for encoder_16_to_4_queue: one high-priority and one low-priority instance.
module tb_encoder_16_to_4_queue;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic        out_ready;
  logic [3:0]  out_code;
  logic        out_valid;
  logic [15:0] pending;
  logic        any;

  logic        enable_lo;
  logic [15:0] req_lo;
  logic        out_ready_lo;
  logic [3:0]  out_code_lo;
  logic        out_valid_lo;
  logic [15:0] pending_lo;
  logic        any_lo;

  int vectors;
  int miscompares;

  encoder_16_to_4_queue #(.PRIORITY_HIGH(1)) dut_hi (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .any       (any)
  );

  encoder_16_to_4_queue #(.PRIORITY_HIGH(0)) dut_lo (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable_lo),
    .req       (req_lo),
    .out_code  (out_code_lo),
    .out_valid (out_valid_lo),
    .out_ready (out_ready_lo),
    .pending   (pending_lo),
    .any       (any_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 16'hFFFF; req_lo = 16'hFFFF;
    tick(); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid got %b want 0", out_valid); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_pending got %h want 0000", pending); end
    vectors++; if (any !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_any got %b want 0", any); end
    vectors++; if (out_valid_lo !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid_lo got %b want 0", out_valid_lo); end
    req = 16'h0000; req_lo = 16'h0000;
    rst_n = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_valid got %b want 0", out_valid); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("[TB] FAIL post_rst_pending got %h want 0000", pending); end
    vectors++; if (out_code !== 4'd0) begin miscompares++; $display("[TB] FAIL post_rst_code got %0d want 0", out_code); end
    vectors++; if (any !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_any got %b want 0", any); end
  endtask

  task automatic test_single();
    enable = 1'b0; out_ready = 1'b1; req = 16'h0020;
    tick();
    req = 16'h0000;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid got %b want 1", out_valid); end
    vectors++; if (out_code !== 4'd5) begin miscompares++; $display("[TB] FAIL single_code got %0d want 5", out_code); end
    vectors++; if (pending !== 16'h0020) begin miscompares++; $display("[TB] FAIL single_pending got %h want 0020", pending); end
    vectors++; if (any !== 1'b1) begin miscompares++; $display("[TB] FAIL single_any got %b want 1", any); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_drain_valid got %b want 0", out_valid); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("[TB] FAIL single_drain_pending got %h want 0000", pending); end
    vectors++; if (any !== 1'b0) begin miscompares++; $display("[TB] FAIL single_drain_any got %b want 0", any); end
  endtask

  task automatic test_burst();
    logic [3:0] exp_codes [3];
    exp_codes[0] = 4'd8; exp_codes[1] = 4'd0; exp_codes[2] = 4'd0;
    out_ready = 1'b0; req = 16'h8101;
    tick();
    req = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (out_valid !== 1'b1 || out_code !== 4'd15) begin miscompares++; $display("[TB] FAIL burst_hold[%0d] got v=%b c=%0d want v=1 c=15", c, out_valid, out_code); end
      if (c < 4) tick();
    end
    vectors++; if (pending !== 16'h8101) begin miscompares++; $display("[TB] FAIL burst_pending got %h want 8101", pending); end
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++; if (out_valid !== 1'b1 || out_code !== exp_codes[c]) begin miscompares++; $display("[TB] FAIL burst_drain[%0d] got v=%b c=%0d want v=1 c=%0d", c, out_valid, out_code, exp_codes[c]); end
    end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_end_valid got %b want 0", out_valid); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("[TB] FAIL burst_end_pending got %h want 0000", pending); end
  endtask

  task automatic test_back_to_back_rerequest();
    out_ready = 1'b0; req = 16'h0008;
    tick();
    req = 16'h0000;
    vectors++; if (out_valid !== 1'b1 || out_code !== 4'd3) begin miscompares++; $display("[TB] FAIL rereq_first got v=%b c=%0d want v=1 c=3", out_valid, out_code); end
    out_ready = 1'b1; req = 16'h0008;
    tick();
    req = 16'h0000; out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_code !== 4'd3) begin miscompares++; $display("[TB] FAIL rereq_again got v=%b c=%0d want v=1 c=3", out_valid, out_code); end
    vectors++; if (pending[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL rereq_pending3 got %b want 1", pending[3]); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0 || pending !== 16'h0000) begin miscompares++; $display("[TB] FAIL rereq_end got v=%b p=%h want v=0 p=0000", out_valid, pending); end
  endtask

  task automatic test_enable_gating();
    enable = 1'b1; out_ready = 1'b0; req = 16'h0404;
    tick();
    req = 16'h0000;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL en_blocked_valid got %b want 0", out_valid); end
    vectors++; if (pending !== 16'h0404) begin miscompares++; $display("[TB] FAIL en_blocked_pending got %h want 0404", pending); end
    vectors++; if (any !== 1'b1) begin miscompares++; $display("[TB] FAIL en_blocked_any got %b want 1", any); end
    enable = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_code !== 4'd10) begin miscompares++; $display("[TB] FAIL en_load got v=%b c=%0d want v=1 c=10", out_valid, out_code); end
    enable = 1'b1;
    tick(); tick();
    vectors++; if (out_valid !== 1'b1 || out_code !== 4'd10) begin miscompares++; $display("[TB] FAIL en_held got v=%b c=%0d want v=1 c=10", out_valid, out_code); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL en_accept_valid got %b want 0", out_valid); end
    vectors++; if (pending !== 16'h0004) begin miscompares++; $display("[TB] FAIL en_accept_pending got %h want 0004", pending); end
    out_ready = 1'b0; enable = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_code !== 4'd2) begin miscompares++; $display("[TB] FAIL en_resume got v=%b c=%0d want v=1 c=2", out_valid, out_code); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0 || pending !== 16'h0000) begin miscompares++; $display("[TB] FAIL en_end got v=%b p=%h want v=0 p=0000", out_valid, pending); end
  endtask

  task automatic test_priority_low();
    logic [3:0] exp_codes [3];
    exp_codes[0] = 4'd0; exp_codes[1] = 4'd8; exp_codes[2] = 4'd15;
    enable_lo = 1'b0; out_ready_lo = 1'b1; req_lo = 16'h8101;
    for (int c = 0; c < 3; c++) begin
      tick();
      req_lo = 16'h0000;
      vectors++; if (out_valid_lo !== 1'b1 || out_code_lo !== exp_codes[c]) begin miscompares++; $display("[TB] FAIL lo_order[%0d] got v=%b c=%0d want v=1 c=%0d", c, out_valid_lo, out_code_lo, exp_codes[c]); end
    end
    tick();
    vectors++; if (out_valid_lo !== 1'b0 || pending_lo !== 16'h0000) begin miscompares++; $display("[TB] FAIL lo_end got v=%b p=%h want v=0 p=0000", out_valid_lo, pending_lo); end
  endtask

  task automatic test_async_reset();
    enable = 1'b0; out_ready = 1'b0; req = 16'h0101;
    tick();
    req = 16'h0000;
    vectors++; if (out_valid !== 1'b1 || out_code !== 4'd8) begin miscompares++; $display("[TB] FAIL arst_setup got v=%b c=%0d want v=1 c=8", out_valid, out_code); end
    vectors++; if (pending !== 16'h0101) begin miscompares++; $display("[TB] FAIL arst_setup_pending got %h want 0101", pending); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_valid got %b want 0", out_valid); end
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("[TB] FAIL arst_pending got %h want 0000", pending); end
    vectors++; if (any !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_any got %b want 0", any); end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_release_valid got %b want 0", out_valid); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; enable = 1'b1; req = '0; out_ready = 1'b0;
    enable_lo = 1'b1; req_lo = '0; out_ready_lo = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_back_to_back_rerequest();
    test_enable_gating();
    test_priority_low();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
